// File: rtl/scpad_dram_resp_sched_if.sv
// Bundle of allocation, DRAM response and write-latch signals for scpad_dram_resp_sched.
// The slave modport is the scheduler side; master is the requester/DRAM/latch side.
interface scpad_dram_resp_sched_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int ID_W        = 8,
    parameter int ADDR_W      = 16,
    parameter int XBAR_W      = 8
);
    localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

    logic              alloc_valid;
    logic              alloc_ready;
    logic [ADDR_W-1:0] alloc_spad_addr;
    logic [XBAR_W-1:0] alloc_xbar;
    logic [2:0]        alloc_nbeats;
    logic [ID_W-1:0]   alloc_id;

    logic              dram_res_valid;
    logic [ID_W-1:0]   dram_res_id;
    logic [63:0]       dram_rddata;
    logic              dram_res_ready;
    logic              be_stall;

    logic              lat_res_valid;
    logic [ID_W-1:0]   lat_dram_id;
    logic [63:0]       lat_dram_rddata;
    logic [ADDR_W-1:0] lat_spad_addr;
    logic [XBAR_W-1:0] lat_xbar;
    logic [2:0]        lat_num_request;
    logic [2:0]        lat_beat_idx;
    logic              lat_last;
    logic              err_unknown_id;
    logic [CNT_W-1:0]  outstanding;

    modport slave (
        input  alloc_valid, alloc_spad_addr, alloc_xbar, alloc_nbeats,
        input  dram_res_valid, dram_res_id, dram_rddata, be_stall,
        output alloc_ready, alloc_id, dram_res_ready,
        output lat_res_valid, lat_dram_id, lat_dram_rddata, lat_spad_addr, lat_xbar,
        output lat_num_request, lat_beat_idx, lat_last, err_unknown_id, outstanding
    );

    modport master (
        output alloc_valid, alloc_spad_addr, alloc_xbar, alloc_nbeats,
        output dram_res_valid, dram_res_id, dram_rddata, be_stall,
        input  alloc_ready, alloc_id, dram_res_ready,
        input  lat_res_valid, lat_dram_id, lat_dram_rddata, lat_spad_addr, lat_xbar,
        input  lat_num_request, lat_beat_idx, lat_last, err_unknown_id, outstanding
    );
endinterface

// File: rtl/scpad_dram_resp_sched.sv
// Tag table for outstanding scratchpad DRAM reads; matches returning beats to their
// descriptor and hands them to the SRAM write latch through a single output register.
module scpad_dram_resp_sched #(
    parameter int NUM_ENTRIES = 4,
    parameter int ID_W        = 8,
    parameter int ADDR_W      = 16,
    parameter int XBAR_W      = 8
) (
    input logic                  i_clk,
    input logic                  i_nrst,
    scpad_dram_resp_sched_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [ADDR_W-1:0]      r_addr   [NUM_ENTRIES];
    logic [XBAR_W-1:0]      r_xbar   [NUM_ENTRIES];
    logic [2:0]             r_nbeats [NUM_ENTRIES];
    logic [2:0]             r_cnt    [NUM_ENTRIES];

    logic              r_lat_valid;
    logic [ID_W-1:0]   r_lat_id;
    logic [63:0]       r_lat_data;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [XBAR_W-1:0] r_lat_xbar;
    logic [2:0]        r_lat_nreq;
    logic [2:0]        r_lat_idx;
    logic              r_lat_last;
    logic              r_err;
    logic [CNT_W-1:0]  r_outstanding;

    logic                   w_alloc_ready;
    logic                   w_alloc_fire;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_accept;
    logic                   w_in_range;
    logic [IDX_W-1:0]       w_res_idx;
    logic                   w_hit;
    logic                   w_miss;
    logic                   w_hit_last;
    logic [NUM_ENTRIES-1:0] w_valid_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    assign w_alloc_ready = |(~r_valid);
    assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready;

    // Lowest free slot wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
    end

    assign w_accept   = bus.dram_res_valid & ~bus.be_stall;
    assign w_in_range = {1'b0, bus.dram_res_id} < (ID_W + 1)'(NUM_ENTRIES);
    assign w_res_idx  = bus.dram_res_id[IDX_W-1:0];
    assign w_hit      = w_accept & w_in_range & r_valid[w_res_idx];
    assign w_miss     = w_accept & ~(w_in_range & r_valid[w_res_idx]);
    assign w_hit_last = (r_cnt[w_res_idx] == r_nbeats[w_res_idx]);

    // A freshly allocated slot was free, so it can never be the slot being hit.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_alloc_fire)        w_valid_nxt[w_free_idx] = 1'b1;
        if (w_hit && w_hit_last) w_valid_nxt[w_res_idx]  = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_valid_nxt[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_valid       <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) r_cnt[i] <= '0;
            r_lat_valid   <= 1'b0;
            r_lat_id      <= '0;
            r_lat_data    <= '0;
            r_lat_addr    <= '0;
            r_lat_xbar    <= '0;
            r_lat_nreq    <= '0;
            r_lat_idx     <= '0;
            r_lat_last    <= 1'b0;
            r_err         <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_valid       <= w_valid_nxt;
            r_outstanding <= w_cnt_nxt;
            r_err         <= w_miss;
            if (w_alloc_fire) r_cnt[w_free_idx] <= '0;
            if (w_hit)        r_cnt[w_res_idx]  <= w_hit_last ? 3'd0 : r_cnt[w_res_idx] + 3'd1;
            // Stall freezes the output register; no beat is accepted meanwhile.
            if (!bus.be_stall) begin
                r_lat_valid <= w_hit;
                if (w_hit) begin
                    r_lat_id   <= bus.dram_res_id;
                    r_lat_data <= bus.dram_rddata;
                    r_lat_addr <= r_addr[w_res_idx];
                    r_lat_xbar <= r_xbar[w_res_idx];
                    r_lat_nreq <= r_nbeats[w_res_idx];
                    r_lat_idx  <= r_cnt[w_res_idx];
                    r_lat_last <= w_hit_last;
                end
            end
        end
    end

    // Descriptor payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_alloc_fire) begin
            r_addr[w_free_idx]   <= bus.alloc_spad_addr;
            r_xbar[w_free_idx]   <= bus.alloc_xbar;
            r_nbeats[w_free_idx] <= bus.alloc_nbeats;
        end
    end

    assign bus.alloc_ready     = w_alloc_ready;
    assign bus.alloc_id        = ID_W'(w_free_idx);
    assign bus.dram_res_ready  = ~bus.be_stall;
    assign bus.lat_res_valid   = r_lat_valid;
    assign bus.lat_dram_id     = r_lat_id;
    assign bus.lat_dram_rddata = r_lat_data;
    assign bus.lat_spad_addr   = r_lat_addr;
    assign bus.lat_xbar        = r_lat_xbar;
    assign bus.lat_num_request = r_lat_nreq;
    assign bus.lat_beat_idx    = r_lat_idx;
    assign bus.lat_last        = r_lat_last;
    assign bus.err_unknown_id  = r_err;
    assign bus.outstanding     = r_outstanding;
endmodule

// File: tb/tb_scpad_dram_resp_sched.sv
// Directed + randomized bench for scpad_dram_resp_sched against a per-transaction
// beat-count reference model.
module tb_scpad_dram_resp_sched;
    localparam int NE  = 4;
    localparam int IDW = 8;
    localparam int AW  = 16;
    localparam int XW  = 8;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    scpad_dram_resp_sched_if #(.NUM_ENTRIES(NE), .ID_W(IDW), .ADDR_W(AW), .XBAR_W(XW)) bus ();

    scpad_dram_resp_sched #(.NUM_ENTRIES(NE), .ID_W(IDW), .ADDR_W(AW), .XBAR_W(XW)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: which tags are open, their descriptor, and how many beats already went out.
    bit          m_valid [NE];
    logic [AW-1:0] m_addr [NE];
    logic [XW-1:0] m_xbar [NE];
    int          m_nb  [NE];
    int          m_del [NE];

    bit          e_lv;
    logic [IDW-1:0] e_id;
    logic [63:0] e_data;
    logic [AW-1:0] e_addr;
    logic [XW-1:0] e_xbar;
    int          e_nreq;
    int          e_idx;
    bit          e_last;
    bit          e_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NE; i++) if (!m_valid[i]) return i;
        return NE;
    endfunction

    function automatic int open_count();
        int n = 0;
        for (int i = 0; i < NE; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    task automatic set_idle();
        bus.alloc_valid     = 1'b0;
        bus.alloc_spad_addr = '0;
        bus.alloc_xbar      = '0;
        bus.alloc_nbeats    = '0;
        bus.dram_res_valid  = 1'b0;
        bus.dram_res_id     = '0;
        bus.dram_rddata     = '0;
        bus.be_stall        = 1'b0;
    endtask

    task automatic set_alloc(input int addr, input int nb);
        bus.alloc_valid     = 1'b1;
        bus.alloc_spad_addr = AW'(addr);
        bus.alloc_xbar      = XW'($urandom);
        bus.alloc_nbeats    = 3'(nb);
    endtask

    task automatic set_beat(input int id);
        bus.dram_res_valid = 1'b1;
        bus.dram_res_id    = IDW'(id);
        bus.dram_rddata    = {$urandom, $urandom};
    endtask

    // Advance one clock: update the model from the inputs in force, then compare.
    task automatic cycle();
        int  lf, id;
        bit  acc, hit, fin;
        lf  = lowest_free();
        acc = bus.dram_res_valid && !bus.be_stall;
        id  = int'(bus.dram_res_id);
        hit = acc && (id < NE) && m_valid[id % NE];
        if (!nrst) begin
            for (int i = 0; i < NE; i++) begin
                m_valid[i] = 0;
                m_del[i]   = 0;
            end
            e_lv  = 0;
            e_err = 0;
        end else begin
            if (!bus.be_stall) begin
                e_lv  = hit;
                e_err = acc && !hit;
                if (hit) begin
                    e_id   = bus.dram_res_id;
                    e_data = bus.dram_rddata;
                    e_addr = m_addr[id];
                    e_xbar = m_xbar[id];
                    e_nreq = m_nb[id];
                    e_idx  = m_del[id];
                    e_last = (m_del[id] == m_nb[id]);
                end
            end else begin
                e_err = 0;
            end
            if (hit) begin
                fin = (m_del[id] == m_nb[id]);
                m_del[id]   = fin ? 0 : m_del[id] + 1;
                if (fin) m_valid[id] = 0;
            end
            if (bus.alloc_valid && lf < NE) begin
                m_valid[lf] = 1;
                m_addr[lf]  = bus.alloc_spad_addr;
                m_xbar[lf]  = bus.alloc_xbar;
                m_nb[lf]    = int'(bus.alloc_nbeats);
                m_del[lf]   = 0;
            end
        end
        @(posedge clk);
        #1;
        lf = lowest_free();
        chk("alloc_ready", bus.alloc_ready, lf < NE);
        if (lf < NE) chk("alloc_id", bus.alloc_id, lf);
        chk("outstanding", bus.outstanding, open_count());
        chk("lat_res_valid", bus.lat_res_valid, e_lv);
        chk("err_unknown_id", bus.err_unknown_id, e_err);
        chk("dram_res_ready", bus.dram_res_ready, !bus.be_stall);
        if (e_lv) begin
            chk("lat_dram_id", bus.lat_dram_id, e_id);
            chk("lat_dram_rddata", bus.lat_dram_rddata, e_data);
            chk("lat_spad_addr", bus.lat_spad_addr, e_addr);
            chk("lat_xbar", bus.lat_xbar, e_xbar);
            chk("lat_num_request", bus.lat_num_request, e_nreq);
            chk("lat_beat_idx", bus.lat_beat_idx, e_idx);
            chk("lat_last", bus.lat_last, e_last);
        end
    endtask

    initial begin
        logic [63:0] held;
        int          cand [$];
        int          pick;

        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0;
            m_del[i]   = 0;
            m_nb[i]    = 0;
        end
        e_lv = 0; e_err = 0;
        set_idle();

        // Reset
        nrst = 1'b0;
        cycle();
        cycle();
        nrst = 1'b1;
        cycle();
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_alloc_id", bus.alloc_id, 0);
        chk("rst_lat_valid", bus.lat_res_valid, 0);

        // Three allocations: ids 0,1,2
        for (int i = 0; i < 3; i++) begin
            set_alloc(16 * (i + 1), (i == 0) ? 0 : (i == 1) ? 3 : 7);
            #0;
            chk("alloc_id_seq", bus.alloc_id, i);
            cycle();
        end
        set_idle();
        chk("three_outstanding", bus.outstanding, 3);
        chk("three_alloc_ready", bus.alloc_ready, 1);

        // Four back-to-back beats of id 1
        for (int b = 0; b < 4; b++) begin
            set_beat(1);
            cycle();
            chk("b2b_valid", bus.lat_res_valid, 1);
            chk("b2b_idx", bus.lat_beat_idx, b);
            chk("b2b_addr", bus.lat_spad_addr, 16'h0020);
            chk("b2b_last", bus.lat_last, b == 3);
        end
        set_idle();
        cycle();
        chk("id1_freed", bus.outstanding, 2);

        // Fill table (slots 1 and 3), then drain id 2 while alloc_valid is held
        set_alloc(16'h0040, 1);
        cycle();
        set_alloc(16'h0050, 2);
        cycle();
        chk("full_alloc_ready", bus.alloc_ready, 0);
        set_alloc(16'h0060, 7);
        for (int b = 0; b < 8; b++) begin
            set_beat(2);
            cycle();
        end
        chk("freed_alloc_ready", bus.alloc_ready, 1);
        chk("freed_alloc_id", bus.alloc_id, 2);
        bus.dram_res_valid = 1'b0;
        cycle();
        set_idle();
        chk("refill_outstanding", bus.outstanding, 4);

        // Stall with one beat of id 2 in the output register
        set_beat(2);
        held = bus.dram_rddata;
        cycle();
        set_beat(2);
        bus.be_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #0;
            chk("stall_ready", bus.dram_res_ready, 0);
            cycle();
            chk("stall_hold_data", bus.lat_dram_rddata, held);
            chk("stall_hold_idx", bus.lat_beat_idx, 0);
        end
        bus.be_stall = 1'b0;
        held = bus.dram_rddata;
        cycle();
        chk("resume_idx", bus.lat_beat_idx, 1);
        chk("resume_data", bus.lat_dram_rddata, held);
        set_idle();
        cycle();

        // Unknown id, then a beat to a freed entry (id 0 had a single beat)
        set_beat(5);
        cycle();
        chk("unk_err", bus.err_unknown_id, 1);
        chk("unk_no_beat", bus.lat_res_valid, 0);
        set_idle();
        cycle();
        chk("unk_pulse_end", bus.err_unknown_id, 0);
        chk("unk_table", bus.outstanding, 4);
        set_beat(0);
        cycle();
        chk("id0_last", bus.lat_last, 1);
        set_beat(0);
        cycle();
        chk("freed_err", bus.err_unknown_id, 1);
        set_idle();
        cycle();

        // Reset with id 2 at 2 of 8 beats
        nrst = 1'b0;
        cycle();
        nrst = 1'b1;
        chk("midrst_outstanding", bus.outstanding, 0);
        chk("midrst_lat_valid", bus.lat_res_valid, 0);
        set_beat(2);
        cycle();
        chk("midrst_err", bus.err_unknown_id, 1);
        set_idle();
        cycle();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            set_idle();
            if ($urandom_range(2) == 0) set_alloc($urandom, $urandom_range(7));
            if ($urandom_range(1) == 0) begin
                cand.delete();
                for (int i = 0; i < NE; i++) if (m_valid[i]) cand.push_back(i);
                if (cand.size() > 0 && $urandom_range(9) < 8) pick = cand[$urandom_range(cand.size() - 1)];
                else pick = $urandom_range(7);
                set_beat(pick);
            end
            bus.be_stall = ($urandom_range(4) == 0);
            nrst = ($urandom_range(299) != 0);
            cycle();
        end
        nrst = 1'b1;
        set_idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scpad_dram_resp_sched.md
Name: scpad_dram_resp_sched

Overview:
Response scheduler that sits between the scratchpad DRAM read path and the SRAM write latch. It tracks outstanding DRAM read transactions in a small tag table. Each returning 64-bit DRAM beat is matched by dram_id to its descriptor (scratchpad address, xbar descriptor, beat count) and presented to the write latch one beat per cycle, with backpressure driven by be_stall. A table entry is retired when its final beat has been handed to the latch.

Parameters:
NUM_ENTRIES, 4, number of outstanding DRAM read transactions (power of 2, at most 256)
ID_W, 8, dram_id width
ADDR_W, SCPAD_ADDR_WIDTH, scratchpad address width
XBAR_W, $bits(xbar_desc_t), packed xbar descriptor width

Ports:
CLK  input  1  clock
nRST  input  1  synchronous active-low reset
alloc_valid  input  1  requester wants a new transaction tag
alloc_ready  output  1  a free entry exists
alloc_spad_addr  input  ADDR_W  base scratchpad address for the transaction
alloc_xbar  input  XBAR_W  xbar descriptor for the transaction
alloc_nbeats  input  3  beats minus 1 (0..7 means 1..8 beats)
alloc_id  output  ID_W  dram_id to place on the DRAM request; valid while alloc_ready=1
dram_res_valid  input  1  DRAM response beat valid
dram_res_id  input  ID_W  tag of the response beat
dram_rddata  input  64  response data
dram_res_ready  output  1  beat accepted this cycle if dram_res_valid=1
be_stall  input  1  backend/SRAM stall
lat_res_valid  output  1  beat presented to the write latch
lat_dram_id  output  ID_W  tag of the presented beat
lat_dram_rddata  output  64  data of the presented beat
lat_spad_addr  output  ADDR_W  base address of the owning entry
lat_xbar  output  XBAR_W  xbar descriptor of the owning entry
lat_num_request  output  3  nbeats field of the owning entry
lat_beat_idx  output  3  index of this beat within its transaction (0-based)
lat_last  output  1  this beat is the final beat of its transaction
err_unknown_id  output  1  one-cycle pulse: an accepted beat was dropped
outstanding  output  $clog2(NUM_ENTRIES)+1  number of valid entries

Behaviour:
- Reset (nRST=0 at a CLK edge): clear all entry valid bits and beat counters. All outputs go to 0, except alloc_ready=1 and alloc_id=0 once the reset is released. A reset mid-transaction silently discards all in-flight state.
- Entry contents: valid, spad_addr, xbar, nbeats, beat_cnt (3 bits).
- Allocation:
  - alloc_ready = OR of ~valid over all entries, using registered state only.
  - alloc_id = index of the lowest free entry, zero-extended to ID_W.
  - On alloc_valid & alloc_ready: the entry is written at the edge (valid=1, beat_cnt=0); it is usable from the next cycle.
- Response acceptance:
  - dram_res_ready = ~be_stall. A beat is accepted on dram_res_valid & dram_res_ready.
  - Lookup is hit if dram_res_id < NUM_ENTRIES and entry[id].valid=1.
  - On a miss: the beat is dropped, no output beat is produced, and err_unknown_id=1 in the next cycle.
- Output stage (one register, latency 1):
  - On a hit, the next cycle has lat_res_valid=1, lat_dram_rddata=dram_rddata, entry fields on lat_*, lat_beat_idx=beat_cnt, and lat_last=(beat_cnt==nbeats).
  - At the same edge, beat_cnt increments. If lat_last, the entry is freed instead (valid=0, beat_cnt=0).
  - While be_stall=1, the output register holds its value. The latch consumes a beat only on lat_res_valid & ~be_stall.
  - With no accepted hit, lat_res_valid is 0 in the next non-stalled cycle. Back-to-back beats are supported at 1 beat/cycle.
- A beat arriving after its entry reached nbeats+1 beats finds the entry freed and is treated as unknown (miss).
- Simultaneous events:
  - A slot freed by a final beat is not reallocatable in the same cycle (alloc_ready is based on state before the edge).
  - A response to a slot allocated in the same cycle is a miss.
  - Allocation and a response hit to a different slot proceed concurrently.
- outstanding is the registered popcount of the valid bits.

Test Plan:
- Allocate 3 transactions (nbeats=0, 3, 7; addrs 0x10/0x20/0x30) -> alloc_id 0, 1, 2; outstanding=3; alloc_ready stays 1.
- Return the 4 beats of id 1 back-to-back -> lat_res_valid on 4 consecutive cycles, lat_beat_idx 0..3, lat_spad_addr=0x20, lat_last only on idx 3; entry 1 freed; outstanding drops by 1.
- Fill all 4 entries -> alloc_ready=0. Final beat of id 2, with alloc_valid held -> alloc_ready=1 the next cycle, alloc_id=2.
- Hold be_stall=1 for 3 cycles with one beat in the output register and dram_res_valid=1 -> dram_res_ready=0, lat_* stable for 3 cycles, no beat lost; on release, beats resume in order.
- Response with id=5 (NUM_ENTRIES=4), or to a freed entry -> no lat_res_valid, err_unknown_id pulses exactly 1 cycle, table unchanged.
- Assert nRST=0 mid-transaction (2 of 8 beats delivered) -> next cycle outstanding=0, lat_res_valid=0; a later beat for that id raises err_unknown_id.
